// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared definitions for the Never8 program memory.
//   - state_e      : loader FSM states (IDLE / LOAD / RUN)
//   - DEF_*        : default word width, address width and depth
//   - even_parity  : even-parity bit over a (zero-extended) data word
package prog_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  // Widest word the parity helper accepts; callers zero-extend, which does
  // not change the XOR reduction.
  localparam int PAR_MAX_W = 64;

  // Bit that makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/prog_mem_if.sv
// prog_mem_if: fetch and loader handshake bundle for prog_mem_loader.
//   fetch_*  : CPU request/valid read port (1-cycle latency)
//   load_*   : host/UART sequential image loader
// Modports:
//   master : CPU/host side (drives requests and load words)
//   slave  : memory side (prog_mem_loader)
interface prog_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;

  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_end;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W:0]   load_count;

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_data, load_end,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err,
           load_busy, load_done, load_count
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_end,
    output fetch_ready, fetch_valid, fetch_data, fetch_err,
           load_busy, load_done, load_count
  );
endinterface

// File: rtl/prog_mem_ram.sv
// prog_mem_ram: single-port synchronous RAM, registered read data.
//   clk  : clock
//   en   : port enable (read or write this cycle)
//   we   : write enable (with en); a write does not update dout
//   addr : word address
//   din  : write data
//   dout : read data, valid the cycle after an enabled read, held otherwise
module prog_mem_ram #(
  parameter int W     = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout_q    <= mem[addr];
    end
  end

  assign dout = dout_q;
endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: parametrised Never8 program memory with image loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : prog_mem_if.slave (fetch port + loader port)
//   parity_err : sticky read-parity error (only with PROG_MEM_PARITY_EN)
// Optional feature macro: PROG_MEM_PARITY_EN -- stores an even-parity bit
// per word and flags mismatches on read.
// Fetches are served in IDLE and RUN; LOAD blocks them, so the single RAM
// port is never shared between a write and a read in the same cycle.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  prog_mem_if.slave bus
`ifdef PROG_MEM_PARITY_EN
  ,
  output logic parity_err
`endif
);

`ifdef PROG_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD = 2'(ST_LOAD);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  logic [1:0]      state_q, state_d;
  logic [ADDR_W:0] load_count_q, load_count_d;
  logic            load_done_q, load_done_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            fetch_err_q, fetch_err_d;
  // Forces fetch_data to 0 after an out-of-range fetch (and after reset);
  // only updated on accepted fetches so the output holds between results.
  logic            zero_q, zero_d;

  logic              fetch_acc, fetch_oor, wr;
  logic [ADDR_W:0]   count_inc;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [MEM_W-1:0]  ram_din, ram_dout;

  assign fetch_acc = bus.fetch_req && (state_q != S_LOAD) && !bus.load_start;
  assign fetch_oor = {1'b0, bus.fetch_addr} >= DEPTH_L;
  assign count_inc = load_count_q + ONE_L;

`ifdef PROG_MEM_PARITY_EN
  assign ram_din = {even_parity(PAR_MAX_W'(bus.load_data)), bus.load_data};
`else
  assign ram_din = bus.load_data;
`endif

  always_comb begin
    state_d       = state_q;
    load_count_d  = load_count_q;
    load_done_d   = 1'b0;
    zero_d        = zero_q;
    fetch_valid_d = fetch_acc;
    fetch_err_d   = fetch_acc && fetch_oor;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = bus.fetch_addr;
    wr            = 1'b0;

    // Out-of-range reads never touch the RAM (index would exceed DEPTH).
    if (fetch_acc) begin
      zero_d = fetch_oor;
      ram_en = !fetch_oor;
    end

    if (bus.load_start) begin
      // Start or restart: memory keeps its old contents.
      state_d      = S_LOAD;
      load_count_d = '0;
    end else if (state_q == S_LOAD) begin
      wr = bus.load_valid && (load_count_q < DEPTH_L);
      if (wr) begin
        ram_en       = 1'b1;
        ram_we       = 1'b1;
        ram_addr     = load_count_q[ADDR_W-1:0];
        load_count_d = count_inc;
      end
      // A word presented together with load_end is still written above.
      if ((wr && count_inc == DEPTH_L) || bus.load_end) begin
        state_d     = S_RUN;
        load_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      load_count_q  <= '0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      zero_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      load_count_q  <= load_count_d;
      load_done_q   <= load_done_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      zero_q        <= zero_d;
    end
  end

  prog_mem_ram #(.W(MEM_W), .AW(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

`ifdef PROG_MEM_PARITY_EN
  logic parity_err_q, parity_err_d;
  logic par_bad;

  // ram_dout is fresh exactly when an in-range fetch result is presented.
  assign par_bad = fetch_valid_q && !fetch_err_q &&
                   (even_parity(PAR_MAX_W'(ram_dout[DATA_W-1:0])) != ram_dout[DATA_W]);

  always_comb begin
    parity_err_d = parity_err_q | par_bad;
    if (bus.load_start) parity_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`endif

  assign bus.fetch_ready = fetch_acc;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.fetch_data  = zero_q ? '0 : ram_dout[DATA_W-1:0];
  assign bus.load_busy   = (state_q == S_LOAD);
  assign bus.load_done   = load_done_q;
  assign bus.load_count  = load_count_q;

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Parametrised program memory for the Never8 core, generalising the fixed 8-bit/256-entry program_mem.
- Adds a sequential loader port (host/UART side) that writes the image word by word.
- Adds a request/valid fetch port for the CPU with fixed 1-cycle read latency.
- Adds range checking for non-power-of-two depths.
- Sits between the boot loader and the CPU fetch stage.

Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  CPU read request, sampled each cycle.
- fetch_addr  in  ADDR_W  CPU read address.
- fetch_ready  out  1  high when a fetch_req is accepted this cycle.
- fetch_valid  out  1  fetch_data is valid this cycle.
- fetch_data  out  DATA_W  read word.
- fetch_err  out  1  qualifies fetch_valid; the address was >= DEPTH.
- load_start  in  1  pulse that begins an image load at address 0.
- load_valid  in  1  load_data is present this cycle.
- load_data  in  DATA_W  word to write.
- load_end  in  1  host terminates the load early.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset values (asynchronous): state IDLE, fetch_ready 0, fetch_valid 0, fetch_data 0, fetch_err 0, load_busy 0, load_done 0, load_count 0. Memory contents are not reset.
- States: IDLE, LOAD, RUN.
  - IDLE: on load_start go to LOAD. Otherwise fetches are served, same as RUN.
  - LOAD: each cycle with load_valid high writes load_data to mem[load_count], then load_count increments.
  - LOAD exits to RUN with a load_done pulse in the cycle after either of these:
    - the write that makes load_count == DEPTH;
    - load_end high (a load_valid in the same cycle is still written first).
  - load_valid outside LOAD is ignored.
  - load_start in LOAD or RUN restarts the load: load_count is cleared to 0 and the state goes to LOAD. Memory is not cleared.
- fetch_ready is combinational: fetch_req && state != LOAD && !load_start.
- On an accepted fetch at cycle N, the outputs at cycle N+1 are:
  - fetch_valid = 1;
  - fetch_data = mem[fetch_addr];
  - fetch_err = 0.
- If fetch_addr >= DEPTH, cycle N+1 instead gives fetch_valid = 1, fetch_err = 1, fetch_data = 0.
- Back-to-back fetches give one result per cycle.
- fetch_data holds its last value when fetch_valid is 0.
- A fetch_req that is not accepted is dropped, not queued. The CPU must retry.
- load_start and fetch_req in the same cycle: the load wins and the fetch is not accepted.
- Reset mid-load: return to IDLE and clear load_count. Words already written remain in memory.
- A read of the address being written in the same cycle is impossible, because fetch is blocked during LOAD.

Optional Feature:
- Macro: PROG_MEM_PARITY_EN.
- When defined:
  - each entry stores an extra even-parity bit over DATA_W, computed at write time;
  - the parity is checked on read;
  - a mismatch sets a sticky output parity_err (1 bit). It is cleared by reset or load_start.
  - fetch_data is returned unchanged on a mismatch.
- When undefined: no parity storage, and the parity_err port does not exist.

Decomposition:
- Shared package prog_mem_pkg holds:
  - the state enum (IDLE/LOAD/RUN);
  - the default DATA_W, ADDR_W and DEPTH localparams;
  - a parity function.
- One sub-module, prog_mem_ram: a single-port synchronous RAM (write enable, address, din, dout registered).
- prog_mem_loader owns the FSM, address muxing, range check and parity.

Test Plan:
- Reset, then load_start, then 4 writes 0x01, 0x02, 0x03, 0x04 with load_end on the 4th -> load_done pulse, load_count = 4, state RUN.
- Fetch addr 0, 1, 2, 3 back-to-back -> fetch_valid every cycle from the next cycle on, data 0x01, 0x02, 0x03, 0x04, fetch_err 0.
- Load all DEPTH words with data = address -> load_done in the cycle after the 256th write; a fetch at 0xFF returns 0xFF.
- DEPTH = 200, fetch addr 0xC8 -> fetch_valid 1, fetch_err 1, fetch_data 0x00.
- fetch_req and load_start in the same cycle -> fetch_ready 0, no fetch_valid next cycle, load_busy 1; a fetch during LOAD is also refused.
- rst_n low mid-load after 2 words -> all outputs return to reset values; a later fetch at addr 1 returns the second written word.
